// File: rtl/gt_packet_checker.sv
// Receive-side GT lane checker: comma-driven byte-lane alignment, then packet
// framing, length and payload verification with clearable packet/error counters.
module gt_packet_checker #(
    parameter int BYTES    = 4,
    parameter int LEN_W    = 16,
    parameter int MAX_LEN  = 1024,
    parameter int CNT_W    = 32,
    parameter int LOCK_CNT = 4,
    localparam int OFF_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    input  logic [8*BYTES-1:0]   gt_rx_data,
    input  logic [BYTES-1:0]     gt_rx_ctrl,
    input  logic                 clr_cnt,
    output logic [8*BYTES-1:0]   rx_data_align,
    output logic [BYTES-1:0]     rx_ctrl_align,
    output logic [OFF_W-1:0]     align_offset,
    output logic                 align_locked,
    output logic                 pkt_done,
    output logic                 pkt_err,
    output logic [2:0]           err_code,
    output logic [CNT_W-1:0]     packet_cnt_o,
    output logic [CNT_W-1:0]     error_packet_cnt_o
);

    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam logic [LCK_W-1:0] LOCK_MAX  = LCK_W'(LOCK_CNT);
    localparam logic [LEN_W:0]   MAX_LEN_V = (LEN_W + 1)'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, EOP} state_t;

    logic [8*BYTES-1:0] prev_data_q, prev_data_d;
    logic [BYTES-1:0]   prev_ctrl_q, prev_ctrl_d;
    logic [8*BYTES-1:0] rx_data_align_q, rx_data_align_d;
    logic [BYTES-1:0]   rx_ctrl_align_q, rx_ctrl_align_d;
    logic [OFF_W-1:0]   align_offset_q, align_offset_d;
    logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               align_locked_q, align_locked_d;
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               bad_q, bad_d;
    logic               pkt_done_q, pkt_done_d;
    logic               pkt_err_q, pkt_err_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   packet_cnt_q, packet_cnt_d;
    logic [CNT_W-1:0]   error_packet_cnt_q, error_packet_cnt_d;

    logic [16*BYTES-1:0] win_data;
    logic [2*BYTES-1:0]  win_ctrl;
    logic                comma_found;
    logic [OFF_W-1:0]    comma_lane;
    logic                lane_change;
    logic                term;
    logic                term_bad;
    logic [2:0]          term_code;
    logic [LEN_W-1:0]    len_field;
    logic [7:0]          idx_byte;

    // Lowest lane carrying a K28.5 comma wins, hence the descending scan.
    always_comb begin
        comma_found = 1'b0;
        comma_lane  = '0;
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (gt_rx_data[8*i +: 8] == 8'hBC && gt_rx_ctrl[i]) begin
                comma_found = 1'b1;
                comma_lane  = OFF_W'(i);
            end
        end
    end

    always_comb begin
        prev_data_d     = gt_rx_data;
        prev_ctrl_d     = gt_rx_ctrl;
        win_data        = {gt_rx_data, prev_data_q};
        win_ctrl        = {gt_rx_ctrl, prev_ctrl_q};
        rx_data_align_d = win_data[{align_offset_q, 3'b000} +: 8*BYTES];
        rx_ctrl_align_d = win_ctrl[align_offset_q +: BYTES];
        align_offset_d  = align_offset_q;
        lock_cnt_d      = lock_cnt_q;
        align_locked_d  = align_locked_q;
        lane_change     = 1'b0;
        if (comma_found) begin
            if (comma_lane == align_offset_q) begin
                if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LCK_W'(1);
                align_locked_d = (lock_cnt_d == LOCK_MAX);
            end else begin
                align_offset_d = comma_lane;
                lock_cnt_d     = LCK_W'(1);
                align_locked_d = 1'b0;
                lane_change    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        bad_d     = bad_q;
        term      = 1'b0;
        term_bad  = 1'b0;
        term_code = 3'd0;
        len_field = rx_data_align_q[LEN_W-1:0];
        idx_byte  = 8'(idx_q);
        case (state_q)
            IDLE: begin
                if (rx_data_align_q[7:0] == 8'hFB && rx_ctrl_align_q[0] && align_locked_q)
                    state_d = LEN;
            end
            LEN: begin
                if (len_field == '0 || {1'b0, len_field} > MAX_LEN_V || |rx_ctrl_align_q) begin
                    term      = 1'b1;
                    term_bad  = 1'b1;
                    term_code = 3'd2;
                    state_d   = IDLE;
                end else begin
                    len_d   = len_field;
                    idx_d   = '0;
                    bad_d   = 1'b0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (|rx_ctrl_align_q) begin
                    term      = 1'b1;
                    term_bad  = 1'b1;
                    term_code = 3'd3;
                    state_d   = IDLE;
                end else begin
                    if (rx_data_align_q != {BYTES{idx_byte}}) bad_d = 1'b1;
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_d == len_q) state_d = EOP;
                end
            end
            EOP: begin
                term    = 1'b1;
                state_d = IDLE;
                if (rx_data_align_q[7:0] == 8'hFD && rx_ctrl_align_q[0]) begin
                    term_bad  = bad_q;
                    term_code = 3'd1;
                end else begin
                    term_bad  = 1'b1;
                    term_code = 3'd4;
                end
            end
            default: state_d = IDLE;
        endcase
        // A lane jump corrupts everything in flight, so it overrides the word-level verdict.
        if (lane_change && state_q != IDLE) begin
            term      = 1'b1;
            term_bad  = 1'b1;
            term_code = 3'd5;
            state_d   = IDLE;
        end
    end

    always_comb begin
        pkt_done_d         = term;
        pkt_err_d          = term && term_bad;
        err_code_d         = (term && term_bad) ? term_code : err_code_q;
        packet_cnt_d       = packet_cnt_q;
        error_packet_cnt_d = error_packet_cnt_q;
        if (clr_cnt) begin
            packet_cnt_d       = '0;
            error_packet_cnt_d = '0;
        end else if (term) begin
            if (packet_cnt_q != {CNT_W{1'b1}}) packet_cnt_d = packet_cnt_q + CNT_W'(1);
            if (term_bad && error_packet_cnt_q != {CNT_W{1'b1}})
                error_packet_cnt_d = error_packet_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            prev_data_q        <= '0;
            prev_ctrl_q        <= '0;
            rx_data_align_q    <= '0;
            rx_ctrl_align_q    <= '0;
            align_offset_q     <= '0;
            lock_cnt_q         <= '0;
            align_locked_q     <= 1'b0;
            state_q            <= IDLE;
            len_q              <= '0;
            idx_q              <= '0;
            bad_q              <= 1'b0;
            pkt_done_q         <= 1'b0;
            pkt_err_q          <= 1'b0;
            err_code_q         <= 3'd0;
            packet_cnt_q       <= '0;
            error_packet_cnt_q <= '0;
        end else begin
            prev_data_q        <= prev_data_d;
            prev_ctrl_q        <= prev_ctrl_d;
            rx_data_align_q    <= rx_data_align_d;
            rx_ctrl_align_q    <= rx_ctrl_align_d;
            align_offset_q     <= align_offset_d;
            lock_cnt_q         <= lock_cnt_d;
            align_locked_q     <= align_locked_d;
            state_q            <= state_d;
            len_q              <= len_d;
            idx_q              <= idx_d;
            bad_q              <= bad_d;
            pkt_done_q         <= pkt_done_d;
            pkt_err_q          <= pkt_err_d;
            err_code_q         <= err_code_d;
            packet_cnt_q       <= packet_cnt_d;
            error_packet_cnt_q <= error_packet_cnt_d;
        end
    end

    assign rx_data_align      = rx_data_align_q;
    assign rx_ctrl_align      = rx_ctrl_align_q;
    assign align_offset       = align_offset_q;
    assign align_locked       = align_locked_q;
    assign pkt_done           = pkt_done_q;
    assign pkt_err            = pkt_err_q;
    assign err_code           = err_code_q;
    assign packet_cnt_o       = packet_cnt_q;
    assign error_packet_cnt_o = error_packet_cnt_q;

endmodule

// File: tb/tb_gt_packet_checker.sv
// Directed bench for gt_packet_checker: a 4-byte lane exercised across shifts and
// error cases, plus 2- and 8-byte instances replaying the basic good packet.
module tb_gt_packet_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt;
    logic [31:0] d4;
    logic [3:0]  k4;
    logic [15:0] d2;
    logic [1:0]  k2;
    logic [63:0] d8;
    logic [7:0]  k8;

    logic [31:0] a_data4, pcnt4, ecnt4;
    logic [3:0]  a_ctrl4;
    logic [1:0]  off4;
    logic        locked4, done4, err4;
    logic [2:0]  code4;

    logic [15:0] a_data2;
    logic [1:0]  a_ctrl2;
    logic [0:0]  off2;
    logic        locked2, done2, err2;
    logic [2:0]  code2;
    logic [31:0] pcnt2, ecnt2;

    logic [63:0] a_data8;
    logic [7:0]  a_ctrl8;
    logic [2:0]  off8;
    logic        locked8, done8, err8;
    logic [2:0]  code8;
    logic [31:0] pcnt8, ecnt8;

    int          vectors = 0;
    int          miscompares = 0;
    int          cur_bytes = 4;
    int          shift = 0;
    logic [63:0] carry_d = '0;
    logic [7:0]  carry_k = '0;
    logic        clr_req = 1'b0;
    logic [31:0] exp_pkt = '0;
    logic [31:0] exp_err = '0;
    logic        sel_done;

    gt_packet_checker #(.BYTES(4)) dut4 (
        .rx_clk(clk), .rst(rst), .gt_rx_data(d4), .gt_rx_ctrl(k4), .clr_cnt(clr_cnt),
        .rx_data_align(a_data4), .rx_ctrl_align(a_ctrl4), .align_offset(off4),
        .align_locked(locked4), .pkt_done(done4), .pkt_err(err4), .err_code(code4),
        .packet_cnt_o(pcnt4), .error_packet_cnt_o(ecnt4)
    );

    gt_packet_checker #(.BYTES(2)) dut2 (
        .rx_clk(clk), .rst(rst), .gt_rx_data(d2), .gt_rx_ctrl(k2), .clr_cnt(clr_cnt),
        .rx_data_align(a_data2), .rx_ctrl_align(a_ctrl2), .align_offset(off2),
        .align_locked(locked2), .pkt_done(done2), .pkt_err(err2), .err_code(code2),
        .packet_cnt_o(pcnt2), .error_packet_cnt_o(ecnt2)
    );

    gt_packet_checker #(.BYTES(8)) dut8 (
        .rx_clk(clk), .rst(rst), .gt_rx_data(d8), .gt_rx_ctrl(k8), .clr_cnt(clr_cnt),
        .rx_data_align(a_data8), .rx_ctrl_align(a_ctrl8), .align_offset(off8),
        .align_locked(locked8), .pkt_done(done8), .pkt_err(err8), .err_code(code8),
        .packet_cnt_o(pcnt8), .error_packet_cnt_o(ecnt8)
    );

    always #5 clk = ~clk;

    assign sel_done = (cur_bytes == 2) ? done2 : (cur_bytes == 8) ? done8 : done4;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one raw GT word just after the edge so it is stable for the next one.
    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k);
        @(posedge clk);
        #1;
        clr_cnt = clr_req;
        d4 = '0; k4 = '0; d2 = '0; k2 = '0; d8 = '0; k8 = '0;
        case (cur_bytes)
            2:       begin d2 = d[15:0]; k2 = k[1:0]; end
            8:       begin d8 = d;       k8 = k;      end
            default: begin d4 = d[31:0]; k4 = k[3:0]; end
        endcase
    endtask

    // Sends a logical (aligned) word, spreading it over raw words with the current byte shift.
    task automatic sendWord(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] dm, raw_d;
        logic [7:0]  km, raw_k;
        dm    = (cur_bytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * cur_bytes)) - 64'd1);
        km    = 8'((16'd1 << cur_bytes) - 16'd1);
        raw_d = ((d << (8 * shift)) | (carry_d >> (8 * (cur_bytes - shift)))) & dm;
        raw_k = ((k << shift) | (carry_k >> (cur_bytes - shift))) & km;
        carry_d = d & dm;
        carry_k = k & km;
        applyStimulus(raw_d, raw_k);
    endtask

    function automatic logic [63:0] payWord(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8{b}};
    endfunction

    task automatic sendPacket(input int len, input int bad_idx, input bit with_eop);
        logic [63:0] w;
        sendWord(64'hFB, 8'h01);
        sendWord(64'(len), 8'h00);
        for (int i = 0; i < len; i++) begin
            w = payWord(i);
            if (i == bad_idx) w[23:16] = 8'hFF;
            sendWord(w, 8'h00);
        end
        sendWord(with_eop ? 64'hFD : 64'hFB, 8'h01);
    endtask

    task automatic sendCommas(input int n);
        for (int i = 0; i < n; i++) sendWord(64'hBC, 8'h01);
    endtask

    task automatic waitDone(input int budget);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            sendWord('0, '0);
            got = sel_done;
        end
        checkOutput("pkt_done_seen", 64'(got), 64'd1);
    endtask

    task automatic checkDut4(input logic e_err, input logic [2:0] e_code);
        checkOutput("pkt_err", 64'(err4), 64'(e_err));
        checkOutput("err_code", 64'(code4), 64'(e_code));
        checkOutput("packet_cnt", 64'(pcnt4), 64'(exp_pkt));
        checkOutput("error_cnt", 64'(ecnt4), 64'(exp_err));
    endtask

    initial begin
        rst = 1'b1; clr_cnt = 1'b0;
        d4 = '0; k4 = '0; d2 = '0; k2 = '0; d8 = '0; k8 = '0;
        repeat (3) applyStimulus('0, '0);
        checkOutput("rst_align_data", 64'(a_data4), 64'd0);
        checkOutput("rst_locked", 64'(locked4), 64'd0);
        checkOutput("rst_offset", 64'(off4), 64'd0);
        checkOutput("rst_done", 64'(done4), 64'd0);
        checkOutput("rst_pkt_cnt", 64'(pcnt4), 64'd0);
        checkOutput("rst_err_cnt", 64'(ecnt4), 64'd0);
        rst = 1'b0;

        $display("[TB] lane-0 lock and good packet");
        sendWord('0, '0);
        sendCommas(4);
        checkOutput("lock_after_3", 64'(locked4), 64'd0);
        sendWord('0, '0);
        checkOutput("lock_after_4", 64'(locked4), 64'd1);
        checkOutput("offset_lane0", 64'(off4), 64'd0);
        sendPacket(4, -1, 1'b1);
        sendWord('0, '0);
        sendWord('0, '0);
        checkOutput("eop_on_align", 64'(a_data4), 64'h0000_00FD);
        checkOutput("eop_ctrl_align", 64'(a_ctrl4), 64'h1);
        checkOutput("done_not_early", 64'(done4), 64'd0);
        sendWord('0, '0);
        checkOutput("done_pulse", 64'(done4), 64'd1);
        exp_pkt = 1; exp_err = 0;
        checkDut4(1'b0, 3'd0);
        sendWord('0, '0);
        checkOutput("done_one_cycle", 64'(done4), 64'd0);

        $display("[TB] stream shifted by two bytes");
        shift = 2;
        sendWord('0, '0);
        sendWord('0, '0);
        sendCommas(4);
        sendWord('0, '0);
        checkOutput("offset_lane2", 64'(off4), 64'd2);
        checkOutput("lock_lane2", 64'(locked4), 64'd1);
        sendWord('0, '0);
        sendWord(64'hFB, 8'h01);
        sendWord(64'd4, 8'h00);
        checkOutput("sop_not_yet", 64'(a_data4), 64'd0);
        sendWord(payWord(0), 8'h00);
        checkOutput("sop_align_data", 64'(a_data4), 64'h0000_00FB);
        checkOutput("sop_align_ctrl", 64'(a_ctrl4), 64'h1);
        for (int i = 1; i < 4; i++) sendWord(payWord(i), 8'h00);
        sendWord(64'hFD, 8'h01);
        waitDone(8);
        exp_pkt = 2;
        checkDut4(1'b0, 3'd0);

        clr_req = 1'b1;
        sendWord('0, '0);
        clr_req = 1'b0;
        sendWord('0, '0);
        exp_pkt = 0; exp_err = 0;
        checkOutput("clr_pkt_cnt", 64'(pcnt4), 64'd0);
        checkOutput("clr_err_cnt", 64'(ecnt4), 64'd0);

        $display("[TB] payload mismatch then good packet");
        sendPacket(4, 2, 1'b1);
        waitDone(8);
        exp_pkt = 1; exp_err = 1;
        checkDut4(1'b1, 3'd1);
        sendPacket(4, -1, 1'b1);
        waitDone(8);
        exp_pkt = 2;
        checkDut4(1'b0, 3'd1);

        $display("[TB] illegal lengths");
        sendWord(64'hFB, 8'h01);
        sendWord(64'd0, 8'h00);
        waitDone(8);
        exp_pkt = 3; exp_err = 2;
        checkDut4(1'b1, 3'd2);
        sendWord(64'hFB, 8'h01);
        sendWord(64'd1025, 8'h00);
        waitDone(8);
        exp_pkt = 4; exp_err = 3;
        checkDut4(1'b1, 3'd2);
        sendPacket(4, -1, 1'b1);
        waitDone(8);
        exp_pkt = 5;
        checkDut4(1'b0, 3'd2);
        sendPacket(1024, -1, 1'b1);
        waitDone(8);
        exp_pkt = 6;
        checkDut4(1'b0, 3'd2);

        $display("[TB] comma jumps to lane 1 mid-payload");
        sendWord(64'hFB, 8'h01);
        sendWord(64'd4, 8'h00);
        sendWord(payWord(0), 8'h00);
        sendWord(payWord(1), 8'h00);
        applyStimulus(64'h0000_BC00, 8'h02);
        waitDone(6);
        exp_pkt = 7; exp_err = 4;
        checkDut4(1'b1, 3'd5);
        checkOutput("abort_unlocked", 64'(locked4), 64'd0);
        checkOutput("abort_offset", 64'(off4), 64'd1);
        shift = 1; carry_d = '0; carry_k = '0;
        sendCommas(2);
        sendWord('0, '0);
        checkOutput("relock_after_3", 64'(locked4), 64'd0);
        sendCommas(1);
        sendWord('0, '0);
        checkOutput("relock_after_4", 64'(locked4), 64'd1);
        checkOutput("relock_offset", 64'(off4), 64'd1);

        $display("[TB] missing EOP, then clear racing a termination");
        sendWord('0, '0);
        sendPacket(4, -1, 1'b0);
        waitDone(8);
        exp_pkt = 8; exp_err = 5;
        checkDut4(1'b1, 3'd4);
        sendPacket(4, -1, 1'b1);
        sendWord('0, '0);
        clr_req = 1'b1;
        sendWord('0, '0);
        clr_req = 1'b0;
        sendWord('0, '0);
        checkOutput("clr_race_done", 64'(done4), 64'd1);
        exp_pkt = 0; exp_err = 0;
        checkDut4(1'b0, 3'd4);

        $display("[TB] 2-byte and 8-byte datapaths");
        cur_bytes = 2; shift = 0; carry_d = '0; carry_k = '0;
        sendWord('0, '0);
        sendCommas(4);
        sendWord('0, '0);
        checkOutput("b2_locked", 64'(locked2), 64'd1);
        checkOutput("b2_offset", 64'(off2), 64'd0);
        sendPacket(4, -1, 1'b1);
        waitDone(8);
        checkOutput("b2_pkt_err", 64'(err2), 64'd0);
        checkOutput("b2_pkt_cnt", 64'(pcnt2), 64'd1);
        checkOutput("b2_err_cnt", 64'(ecnt2), 64'd0);

        cur_bytes = 8; carry_d = '0; carry_k = '0;
        sendWord('0, '0);
        sendCommas(4);
        sendWord('0, '0);
        checkOutput("b8_locked", 64'(locked8), 64'd1);
        checkOutput("b8_offset", 64'(off8), 64'd0);
        sendPacket(4, -1, 1'b1);
        waitDone(8);
        checkOutput("b8_pkt_err", 64'(err8), 64'd0);
        checkOutput("b8_pkt_cnt", 64'(pcnt8), 64'd1);
        checkOutput("b8_err_cnt", 64'(ecnt8), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
